// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_if
//  Purpose  : Operand, control and HI/LO result bundle for muldiv_unit.
//  Revision : 1.0  initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative shift-add multiply / restoring divide into HI/LO.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    muldiv_if.slave   bus
);
    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_is_div;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic               w_rt_zero;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_top;
    logic [WIDTH-1:0]   w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;

    assign w_signed  = ~bus.op[0];
    assign w_is_div  = bus.op[1];
    assign w_rs_neg  = w_signed & bus.rs_data[WIDTH-1];
    assign w_rt_neg  = w_signed & bus.rt_data[WIDTH-1];
    assign w_rt_zero = (bus.rt_data == '0);
    assign w_rs_mag  = w_rs_neg ? -bus.rs_data : bus.rs_data;
    assign w_rt_mag  = w_rt_neg ? -bus.rt_data : bus.rt_data;

    // Multiply: accumulator = {partial product, remaining multiplier bits}
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + ({(WIDTH+1){r_acc[0]}} & {1'b0, r_opnd});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: accumulator = {partial remainder, dividend bits / quotient bits}
    assign w_div_top  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ge   = (w_div_top >= {1'b0, r_opnd});
    assign w_div_diff = w_div_top[WIDTH-1:0] - r_opnd;
    assign w_div_next = w_div_ge ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                                 : {r_acc[2*WIDTH-2:0], 1'b0};

    assign w_prod = r_neg_res ? -r_acc : r_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= 2'd0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op      <= bus.op;
                        r_opnd    <= w_is_div ? w_rt_mag : w_rs_mag;
                        r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_rs_mag : w_rt_mag)};
                        // Divide-by-zero keeps the raw all-ones quotient
                        r_neg_res <= (w_rs_neg ^ w_rt_neg) & ~(w_is_div & w_rt_zero);
                        r_neg_rem <= w_is_div & w_rs_neg;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
                    end else begin
                        if (bus.hi_we) r_hi <= bus.wdata;
                        if (bus.lo_we) r_lo <= bus.wdata;
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_op[1]) begin
                        r_lo <= r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                        r_hi <= r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Self-checking bench for muldiv_unit against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk;
    logic rst_n;
    bit   chk_en;
    int   n_cmp;
    int   n_err;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result of one operation, straight from the arithmetic definition
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint     sa, sb, q, r;
        logic [63:0] p;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd0: begin p = 64'(sa * sb); return p; end
            2'd1: begin p = ua * ub; return p; end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                p = ua / ub;
                return {32'(ua % ub), p[31:0]};
            end
        endcase
    endfunction

    // Transaction-level model: fixed latency, HI/LO written on completion
    int          m_cnt;
    logic [63:0] m_pend;
    logic [31:0] m_hi, m_lo;
    logic        m_done;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end else if (bus.start) begin
                m_pend <= ref_result(bus.op, bus.rs_data, bus.rt_data);
                m_cnt  <= LAT;
            end else begin
                if (bus.hi_we) m_hi <= bus.wdata;
                if (bus.lo_we) m_lo <= bus.wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", 64'(bus.busy), 64'(m_cnt != 0));
            check("model_done", 64'(bus.done), 64'(m_done));
            check("model_hi",   64'(bus.hi),   64'(m_hi));
            check("model_lo",   64'(bus.lo),   64'(m_lo));
        end
    end

    // Called one tick after an edge; start is sampled on the next edge (E0)
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input string nm, input int inj);
        int cyc;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
        cyc = 0;
        while (!bus.done && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (inj != 0 && cyc == inj) begin
                bus.start = 1'b1;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
        end
        check({nm, "_latency"}, 64'(cyc), 64'(LAT));
        check({nm, "_hi"}, 64'(bus.hi), 64'(ehi));
        check({nm, "_lo"}, 64'(bus.lo), 64'(elo));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        chk_en = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'd0; bus.rs_data = '0; bus.rt_data = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi",   64'(bus.hi),   64'd0);
        check("rst_lo",   64'(bus.lo),   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Consecutive calls issue start in the previous op's done cycle
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 0);
        run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu", 0);
        run_op(2'd3, 32'h0000_0064, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, "divu_by0", 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf", 0);
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, "div_pos_neg", 0);
        run_op(2'd2, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, "div_by0_neg", 0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mult_min", 0);
        run_op(2'd1, 32'd3, 32'd4, 32'd0, 32'd12, "multu_inject", 5);

        @(posedge clk); #1;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_1234;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("mtx_hi", 64'(bus.hi), 64'h1234);
        check("mtx_lo", 64'(bus.lo), 64'h1234);

        // Start together with writes: writes dropped
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_BEEF;
        run_op(2'd1, 32'd3, 32'd5, 32'd0, 32'd15, "start_wins", 0);

        // Reset in the middle of a calculation
        bus.start = 1'b1; bus.op = 2'd3; bus.rs_data = 32'd1000; bus.rt_data = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_hi",   64'(bus.hi),   64'd0);
        check("midrst_lo",   64'(bus.lo),   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'd3, 32'd1000, 32'd3, 32'd1, 32'd333, "after_rst", 0);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
